// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//
// Loadable synchronous down-counter used as an interval / timeout timer. A load
// captures a start value, which is also kept as the reload value. The count
// then decrements once per enabled clock. When it expires, a one-cycle
// terminal-count pulse is produced. With auto_reload the counter restarts from
// the stored reload value. Without it, the counter parks at zero.
//
// Handshake / control semantics:
//   load, stop and enable are level-sampled strobes on each rising clk edge.
//   Priority at every edge is reset_n=0 > load > stop > decrement > hold.
//   No input reaches count, tc or busy without passing through a flop.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   load         in   synchronous load strobe
//   load_value   in   [WIDTH] start / reload value captured on load
//   enable       in   count enable (only effective while running)
//   stop         in   synchronous abort: RUN -> IDLE, count held
//   auto_reload  in   sampled on the expiry edge: 1 reload and keep running
//   count        out  [WIDTH] current counter value (registered)
//   zero         out  count == 0 (decoded from the count register only)
//   tc           out  registered terminal-count pulse
//   busy         out  registered, high while the FSM is in RUN
//   dbg_state    out  FSM state for checkers (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             busy,
    output logic             dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             w_expiry;

    // An expiry is the enabled edge that would take the count from 1 to 0.
    // RUN with count 0 cannot occur, so <= covers only the count==1 case but
    // keeps the counter from ever wrapping if that invariant were broken.
    assign w_expiry = (r_state == ST_RUN) && enable && (r_count <= ONE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / next-datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (load) begin
            // A load always restarts the timer and replaces the reload value.
            // A load of zero parks the block in IDLE without a pulse.
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_state_nxt  = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Count holds. Enable and stop are ignored here.
                    w_state_nxt = ST_IDLE;
                end
                ST_RUN: begin
                    if (stop) begin
                        // An abort wins over an expiry on the same edge.
                        // The count freezes where it is.
                        w_state_nxt = ST_IDLE;
                    end else if (w_expiry) begin
                        w_tc_nxt = 1'b1;
                        if (auto_reload) begin
                            w_count_nxt = r_reload;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (enable) begin
                        w_count_nxt = r_count - ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign count     = r_count;
    assign zero      = (r_count == '0);
    assign tc        = r_tc;
    assign busy      = (r_state == ST_RUN);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         enable;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         zero;
  logic         tc;
  logic         busy;
  logic         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int tc_seen = 0;

  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .zero        (zero),
    .tc          (tc),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model: the timer is described by the number of enabled ticks
  // since the last load (m_k) and the loaded period (m_rel). The visible
  // count is derived arithmetically, and expiries are the multiples of m_rel.
  // ---------------------------------------------------------------------------
  int m_rel;
  int m_k;
  bit m_run;
  bit m_done;
  bit m_tc;

  function automatic void model_reset();
    m_rel  = 0;
    m_k    = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    m_tc   = 1'b0;
  endfunction

  function automatic int model_count();
    if (m_rel == 0 || m_done) return 0;
    return m_rel - (m_k % m_rel);
  endfunction

  function automatic void model_step();
    m_tc = 1'b0;
    if (load) begin
      m_rel  = int'(load_value);
      m_k    = 0;
      m_run  = (load_value != 0);
      m_done = 1'b0;
    end else if (m_run && stop) begin
      m_run = 1'b0;
    end else if (m_run && enable) begin
      m_k = m_k + 1;
      if (m_k % m_rel == 0) begin
        m_tc = 1'b1;
        if (!auto_reload) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_count()));
    check({tag, ".zero"},  32'(zero),  32'(model_count() == 0));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".busy"},  32'(busy),  32'(m_run));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    load        = 1'b0;
    load_value  = '0;
    enable      = 1'b0;
    stop        = 1'b0;
    auto_reload = 1'b0;
  endtask

  // One clock: the model sees the same inputs the DUT samples on this edge,
  // and the outputs are checked 1 time unit later.
  task automatic tick(input string tag);
    logic [W-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
    if (tc) tc_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".seq"}, 32'(count), 32'(e));
    end
  endtask

  task automatic do_load(input logic [W-1:0] v, input string tag);
    load       = 1'b1;
    load_value = v;
    tick(tag);
    load       = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    #12;
    check("reset.count", 32'(count), 32'd0);
    check("reset.zero",  32'(zero),  32'd1);
    check("reset.busy",  32'(busy),  32'd0);
    check("reset.tc",    32'(tc),    32'd0);
    #3 reset_n = 1'b1;

    // One-shot countdown from 5.
    enable = 1'b1;
    exp_q = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    tc_seen = 0;
    do_load(4'd5, "oneshot");
    for (int i = 0; i < 7; i++) tick("oneshot");
    check("oneshot.tc_total", 32'(tc_seen), 32'd1);
    check("oneshot.busy_end", 32'(busy), 32'd0);

    // Auto-reload with period 3: 12 enabled cycles give 4 pulses.
    auto_reload = 1'b1;
    exp_q = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    do_load(4'd3, "autoreload");
    tc_seen = 0;
    for (int i = 0; i < 12; i++) tick("autoreload");
    check("autoreload.tc_total", 32'(tc_seen), 32'd4);
    check("autoreload.busy", 32'(busy), 32'd1);
    auto_reload = 1'b0;

    // Enable gating.
    enable = 1'b0;
    exp_q = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    do_load(4'd4, "gating");
    tc_seen = 0;
    begin
      logic [5:0] pat;
      pat = 6'b111001;  // applied LSB first: 1,0,0,1,1,1
      for (int i = 0; i < 6; i++) begin
        enable = pat[i];
        tick("gating");
      end
    end
    check("gating.tc_total", 32'(tc_seen), 32'd1);

    // Stop and restart.
    enable = 1'b1;
    exp_q = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd6, 4'd6, 4'd6};
    do_load(4'd9, "stop");
    for (int i = 0; i < 3; i++) tick("stop");
    stop = 1'b1;
    tick("stop");
    stop = 1'b0;
    tick("stop");
    tick("stop");
    check("stop.busy", 32'(busy), 32'd0);
    exp_q = '{4'd2, 4'd1, 4'd0};
    tc_seen = 0;
    do_load(4'd2, "restart");
    tick("restart");
    tick("restart");
    check("restart.tc_total", 32'(tc_seen), 32'd1);

    // Load zero.
    do_load(4'd0, "load0");
    check("load0.busy", 32'(busy), 32'd0);
    check("load0.zero", 32'(zero), 32'd1);
    check("load0.tc",   32'(tc),   32'd0);

    // Load together with stop.
    stop = 1'b1;
    do_load(4'd7, "loadstop");
    stop = 1'b0;
    check("loadstop.count", 32'(count), 32'd7);
    check("loadstop.busy",  32'(busy),  32'd1);

    // Load on an expiry edge.
    do_load(4'd2, "loadexp");
    tick("loadexp");
    check("loadexp.pre", 32'(count), 32'd1);
    do_load(4'd15, "loadexp");
    check("loadexp.tc",    32'(tc),    32'd0);
    check("loadexp.count", 32'(count), 32'd15);

    // Stop on an expiry edge.
    do_load(4'd2, "stopexp");
    tick("stopexp");
    stop = 1'b1;
    tick("stopexp");
    stop = 1'b0;
    check("stopexp.count", 32'(count), 32'd1);
    check("stopexp.tc",    32'(tc),    32'd0);

    // Asynchronous reset between edges.
    do_load(4'd12, "asyncrst");
    for (int i = 0; i < 4; i++) tick("asyncrst");
    check("asyncrst.pre", 32'(count), 32'd8);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("asyncrst.count", 32'(count), 32'd0);
    check("asyncrst.busy",  32'(busy),  32'd0);
    check("asyncrst.tc",    32'(tc),    32'd0);
    #1 reset_n = 1'b1;
    enable = 1'b1;
    tick("postrst");
    tick("postrst");
    check("postrst.count", 32'(count), 32'd0);

    // Randomized phase against the reference model.
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      load        = ($urandom_range(0, 7) == 0);
      load_value  = W'($urandom_range(0, (1 << W) - 1));
      stop        = ($urandom_range(0, 9) == 0);
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1) != 0;
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
